// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the parametrised ready/valid FIFO:
//   - clog2 constant function and pointer/count width helpers
//   - handshake event encoding used by the occupancy logic
//   - descriptive constants recording the handshake contract
package fifo_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Pointer indexes 0..depth-1; never narrower than one bit.
  function automatic int ptrWidth(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // Count spans 0..depth inclusive.
  function automatic int countWidth(input int depth);
    return clog2(depth + 1);
  endfunction

  // Handshake event for one clock: {push, pop}.
  typedef enum logic [1:0] {
    HsIdle = 2'b00,
    HsPop  = 2'b01,
    HsPush = 2'b10,
    HsBoth = 2'b11
  } HandshakeT;

  // Handshake contract shared by every user of the FIFO:
  // DataInReady never looks at DataOutReady, and a pushed word becomes
  // visible on the output side one clock after the push edge.
  localparam bit ReadyDependsOnConsumer = 1'b0;
  localparam int PushToValidLatency     = 1;

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
//   Depth x Width register array with one synchronous write port and one
//   asynchronous read port (first-word-fall-through needs the head word
//   without a read cycle).
// Ports:
//   Clock  - write clock (rising edge)
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data, combinational from raddr
module fifo_ram #(
  parameter int Width     = 8,
  parameter int Depth     = 16,
  parameter int AddrWidth = 4
) (
  input  logic                 Clock,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [Width-1:0]     rdata
);

  logic [Width-1:0] mem [Depth];

  // One write decoder per row; contents are deliberately never cleared.
  for (genvar gi = 0; gi < Depth; gi++) begin : gRow
    always_ff @(posedge Clock) begin
      if (we && (waddr == AddrWidth'(gi))) begin
        mem[gi] <= wdata;
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// param_fifo
//   Parametrised first-word-fall-through ready/valid FIFO with occupancy
//   count, programmable almost-full/almost-empty flags, synchronous flush
//   and peak-occupancy tracking.
// Ports:
//   Clock        - single clock, rising edge
//   Reset        - synchronous, active-low; overrides Flush
//   Flush        - synchronous clear of contents, active-high
//   DataIn       - write data;  DataInValid / DataInReady handshake
//   DataOut      - head word;   DataOutValid / DataOutReady handshake
//   Count        - current occupancy 0..Depth
//   MaxCount     - peak Count since last reset/flush
//   AlmostFull   - Count >= AlmostFullLevel
//   AlmostEmpty  - Count <= AlmostEmptyLevel
module param_fifo
  import fifo_pkg::*;
#(
  parameter int Width            = 8,
  parameter int Depth            = 16,
  parameter int AlmostFullLevel  = Depth - 2,
  parameter int AlmostEmptyLevel = 1,
  localparam int CW = countWidth(Depth),
  localparam int PW = ptrWidth(Depth)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Flush,
  input  logic [Width-1:0] DataIn,
  input  logic             DataInValid,
  output logic             DataInReady,
  output logic [Width-1:0] DataOut,
  output logic             DataOutValid,
  input  logic             DataOutReady,
  output logic [CW-1:0]    Count,
  output logic [CW-1:0]    MaxCount,
  output logic             AlmostFull,
  output logic             AlmostEmpty
);

  if (Depth < 2 || Width < 1) begin : gBadSize
    $error("param_fifo: Depth must be >= 2 and Width >= 1");
  end
  if (AlmostFullLevel > Depth) begin : gBadLevel
    $error("param_fifo: AlmostFullLevel must not exceed Depth");
  end

  logic [PW-1:0] rdPtrReg, rdPtrNext;
  logic [PW-1:0] wrPtrReg, wrPtrNext;
  logic [CW-1:0] countReg, countNext;
  logic [CW-1:0] maxCountReg, maxCountNext;
  logic          full, empty, push, pop;
  HandshakeT     hs;

  // Ready/valid come only from registered count, so neither side of the
  // FIFO sees a combinational path through the other. A full FIFO refuses
  // the write even when a pop happens in the same cycle.
  assign full         = (countReg == CW'(Depth));
  assign empty        = (countReg == '0);
  assign DataInReady  = ~full;
  assign DataOutValid = ~empty;
  assign push         = DataInValid & ~full;
  assign pop          = DataOutReady & ~empty;
  assign hs           = HandshakeT'({push, pop});

  always_comb begin
    rdPtrNext    = rdPtrReg;
    wrPtrNext    = wrPtrReg;
    countNext    = countReg;
    case (hs)
      HsPush:  countNext = countReg + CW'(1);
      HsPop:   countNext = countReg - CW'(1);
      default: countNext = countReg;
    endcase
    // Explicit wrap compare keeps non-power-of-two depths correct.
    if (push) begin
      wrPtrNext = (wrPtrReg == PW'(Depth - 1)) ? '0 : wrPtrReg + PW'(1);
    end
    if (pop) begin
      rdPtrNext = (rdPtrReg == PW'(Depth - 1)) ? '0 : rdPtrReg + PW'(1);
    end
    maxCountNext = (countNext > maxCountReg) ? countNext : maxCountReg;
  end

  always_ff @(posedge Clock) begin
    if (!Reset || Flush) begin
      rdPtrReg    <= '0;
      wrPtrReg    <= '0;
      countReg    <= '0;
      maxCountReg <= '0;
    end else begin
      rdPtrReg    <= rdPtrNext;
      wrPtrReg    <= wrPtrNext;
      countReg    <= countNext;
      maxCountReg <= maxCountNext;
    end
  end

  // Writes are suppressed on reset/flush cycles so discarded data never
  // lands in storage.
  fifo_ram #(
    .Width     (Width),
    .Depth     (Depth),
    .AddrWidth (PW)
  ) uRam (
    .Clock (Clock),
    .we    (push & Reset & ~Flush),
    .waddr (wrPtrReg),
    .wdata (DataIn),
    .raddr (rdPtrReg),
    .rdata (DataOut)
  );

  assign Count       = countReg;
  assign MaxCount    = maxCountReg;
  assign AlmostFull  = (int'(countReg) >= AlmostFullLevel);
  assign AlmostEmpty = (int'(countReg) <= AlmostEmptyLevel);

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo
//   Directed bench for param_fifo: instance 0 has Depth=4, instance 1 has
//   Depth=5 (non-power-of-two wrap). A reference model keeps the expected
//   queue contents, count and peak count for each instance.
module tb_param_fifo;

  logic       Clock;
  logic       rstN  [2];
  logic       flush [2];
  logic [7:0] dIn   [2];
  logic       inV   [2];
  logic       inRdy [2];
  logic [7:0] dOut  [2];
  logic       outV  [2];
  logic       outR  [2];
  logic [2:0] cnt   [2];
  logic [2:0] mx    [2];
  logic       aFull [2];
  logic       aEmpty[2];

  int depth [2] = '{4, 5};
  int afl   [2] = '{2, 3};
  int mCount[2];
  int mMax  [2];
  bit known [2];
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];

  int total;
  int bad;

  param_fifo #(.Width(8), .Depth(4)) dut4 (
    .Clock(Clock), .Reset(rstN[0]), .Flush(flush[0]),
    .DataIn(dIn[0]), .DataInValid(inV[0]), .DataInReady(inRdy[0]),
    .DataOut(dOut[0]), .DataOutValid(outV[0]), .DataOutReady(outR[0]),
    .Count(cnt[0]), .MaxCount(mx[0]), .AlmostFull(aFull[0]), .AlmostEmpty(aEmpty[0])
  );

  param_fifo #(.Width(8), .Depth(5)) dut5 (
    .Clock(Clock), .Reset(rstN[1]), .Flush(flush[1]),
    .DataIn(dIn[1]), .DataInValid(inV[1]), .DataInReady(inRdy[1]),
    .DataOut(dOut[1]), .DataOutValid(outV[1]), .DataOutReady(outR[1]),
    .Count(cnt[1]), .MaxCount(mx[1]), .AlmostFull(aFull[1]), .AlmostEmpty(aEmpty[1])
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [7:0] head(input int k);
    return (k == 0) ? sb0[0] : sb1[0];
  endfunction

  task automatic checkOutputs(input int k);
    chk("count", k, 32'(cnt[k]), 32'(mCount[k]));
    chk("max_count", k, 32'(mx[k]), 32'(mMax[k]));
    chk("in_ready", k, 32'(inRdy[k]), 32'(mCount[k] < depth[k]));
    chk("out_valid", k, 32'(outV[k]), 32'(mCount[k] > 0));
    chk("almost_full", k, 32'(aFull[k]), 32'(mCount[k] >= afl[k]));
    chk("almost_empty", k, 32'(aEmpty[k]), 32'(mCount[k] <= 1));
    if (mCount[k] > 0) begin
      chk("data_out", k, 32'(dOut[k]), 32'(head(k)));
    end
  endtask

  // One clock on instance k. Called #1 after a rising edge; drives inputs,
  // checks outputs are independent of them, clocks, updates the model and
  // checks the new state.
  task automatic step(input int k, input logic v, input logic [7:0] d,
                      input logic r, input logic fl, input logic rs);
    bit pu, po;
    inV[k] = v; dIn[k] = d; outR[k] = r; flush[k] = fl; rstN[k] = ~rs;
    #1;
    if (known[k]) checkOutputs(k);
    pu = v && (mCount[k] < depth[k]);
    po = r && (mCount[k] > 0);
    @(posedge Clock);
    #1;
    inV[k] = 1'b0; outR[k] = 1'b0; flush[k] = 1'b0; rstN[k] = 1'b1;
    if (rs || fl) begin
      if (k == 0) sb0.delete(); else sb1.delete();
      mCount[k] = 0;
      mMax[k]   = 0;
      known[k]  = 1'b1;
    end else begin
      if (po) begin
        if (k == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
        mCount[k]--;
      end
      if (pu) begin
        if (k == 0) sb0.push_back(d); else sb1.push_back(d);
        mCount[k]++;
      end
      if (mCount[k] > mMax[k]) mMax[k] = mCount[k];
    end
    checkOutputs(k);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int k = 0; k < 2; k++) begin
      rstN[k] = 1'b0; flush[k] = 1'b0; dIn[k] = 8'h00;
      inV[k] = 1'b0; outR[k] = 1'b0;
      mCount[k] = 0; mMax[k] = 0; known[k] = 1'b0;
    end
    @(posedge Clock);
    #1;

    // Reset then idle.
    step(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Single word held under back-pressure, then consumed.
    step(0, 1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Fill, push while full (pop offered too), drain in order.
    for (int i = 1; i <= 4; i++) step(0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 8'h06, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("max_after_fill", 0, 32'(mx[0]), 32'd4);

    // Depth=5 streaming through the wrap point.
    for (int i = 0; i < 12; i++) step(1, 1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
    step(1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Flush with a simultaneous push; 8'hAA must never appear.
    for (int i = 0; i < 3; i++) step(0, 1'b1, 8'(8'hA1 + i), 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
    chk("count_after_flush", 0, 32'(cnt[0]), 32'd0);
    step(0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream with push and pop active; Flush also high to show
    // reset wins.
    for (int i = 0; i < 3; i++) step(0, 1'b1, 8'(8'hC1 + i), 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    step(0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 8'h5B, 1'b1, 1'b0, 1'b0);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
